// File: rtl/wb_host_pkg.sv
// Purpose: shared types and constants for the Wishbone host initiator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wb_host_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  // Accelerator slave windows; the upper 12 address bits select the window.
  localparam logic [WB_ADR_W-1:0] SUDOKU_BASE = 32'h3000_0000;
  localparam logic [WB_ADR_W-1:0] UART_BASE   = 32'h3080_0000;
  localparam logic [WB_ADR_W-1:0] WINDOW_MASK = 32'hFFF0_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_host_state_e;

  // True when addr falls inside the window starting at base.
  function automatic logic in_window(input logic [WB_ADR_W-1:0] addr,
                                     input logic [WB_ADR_W-1:0] base);
    return (addr & WINDOW_MASK) == base;
  endfunction

endpackage

// File: rtl/wb_host_timeout.sv
// Purpose: watchdog counting Wishbone cycles that have not been acknowledged.
// Latency: expired is combinational from the count; it flags the edge at which the count reaches the limit.
// Backpressure: none; counts only while en is high, saturates at the limit.
module wb_host_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  // Count un-acked bus cycles; cleared whenever no cycle is in flight, never wraps.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && (cnt != CW'(TIMEOUT_CYCLES))) begin
      cnt <= cnt + CW'(1);
    end
  end

  // The increment happening at this edge brings the count to the limit.
  assign expired = en && (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wb_host_master.sv
// Purpose: single-outstanding Wishbone classic initiator bridging a req/rsp valid-ready pair (watchdog under WB_HOST_MASTER_TIMEOUT_EN).
// Latency: request handshake -> cyc/stb next cycle; ack -> rsp_valid next cycle (2 cycles with a zero-wait slave).
// Backpressure: req_ready only in IDLE; the response is held until rsp_ready, blocking new requests.
module wb_host_master
  import wb_host_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [WB_ADR_W-1:0] req_adr,
  input  logic [WB_DAT_W-1:0] req_dat,
  input  logic [WB_SEL_W-1:0] req_sel,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WB_DAT_W-1:0] rsp_dat,
  output logic                rsp_err,
  output logic [WB_ADR_W-1:0] wb_adr_o,
  output logic [WB_DAT_W-1:0] wb_dat_o,
  output logic [WB_SEL_W-1:0] wb_sel_o,
  output logic                wb_we_o,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  input  logic                wb_ack_i,
  input  logic [WB_DAT_W-1:0] wb_dat_i
);

  wb_host_state_e state;
  logic           tmo_expired;

`ifdef WB_HOST_MASTER_TIMEOUT_EN
  wb_host_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .clr     (state != BUS),
    .en      ((state == BUS) && !wb_ack_i),
    .expired (tmo_expired)
  );
`else
  // Without the watchdog a cycle waits for its ack indefinitely.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign tmo_expired        = 1'b0;
`endif

  // Ready only in IDLE and never while reset is held, so nothing is accepted during the reset cycle.
  assign req_ready = (state == IDLE) && !wb_rst_i;

  // Transaction FSM with registered bus and response outputs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
      rsp_err   <= 1'b0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
      wb_sel_o  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            wb_we_o  <= req_we;
            wb_adr_o <= req_adr;
            wb_dat_o <= req_dat;
            wb_sel_o <= req_sel;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            state    <= BUS;
          end
        end
        BUS: begin
          // Ack takes priority over a watchdog expiry on the same edge.
          if (wb_ack_i) begin
            rsp_dat   <= wb_we_o ? '0 : wb_dat_i;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            state     <= RESP;
          end else if (tmo_expired) begin
            rsp_dat   <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_host_master.sv
// Purpose: self-checking bench for wb_host_master with a memory-backed Wishbone slave and a transaction-level reference.
// Latency: checks 2-cycle zero-wait latency, ack-to-response timing and hold under back-pressure.
// Backpressure: exercises rsp_ready stalls with a pending request that must wait for the response to be taken.
module tb_wb_host_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_adr, req_dat;
  logic [3:0]  req_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference word store (indexed by address bits [5:2]) and the slave's own storage.
  logic [31:0] ref_mem   [16];
  logic [31:0] slave_mem [16];

  // Request presented while a response is stalled (back-pressure scenario).
  logic        nxt_we;
  logic [31:0] nxt_adr, nxt_dat;
  logic [3:0]  nxt_sel;

  wb_host_master #(.TIMEOUT_CYCLES(4)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_adr  (req_adr),
    .req_dat  (req_dat),
    .req_sel  (req_sel),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_dat  (rsp_dat),
    .rsp_err  (rsp_err),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_sel_o (wb_sel_o),
    .wb_we_o  (wb_we_o),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_ack_i (wb_ack_i),
    .wb_dat_i (wb_dat_i)
  );

  always #5 clk = ~clk;

  // One full transaction; called at a negedge with the DUT idle. The slave acks in BUS cycle wait_cyc
  // (0 = first), the consumer stalls hold cycles, stray acks are thrown at the RESP state.
  task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int wait_cyc, input int hold, input bit keep_req);
    logic [31:0] exp_dat;
    logic [72:0] got_bus, exp_bus;
    logic [67:0] got_rsp, exp_rsp;
    int idx, sidx;
    idx = int'(adr[5:2]);
    if (we) begin
      exp_dat = 32'h0;
      for (int b = 0; b < 4; b++) if (sel[b]) ref_mem[idx][8*b +: 8] = dat[8*b +: 8];
    end else begin
      exp_dat = ref_mem[idx];
    end
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL txn_req_ready: got %b expected 1", req_ready);
    end
    req_valid = 1'b1; req_we = we; req_adr = adr; req_dat = dat; req_sel = sel;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'($urandom); req_adr = $urandom; req_dat = $urandom; req_sel = 4'($urandom);
    for (int c = 0; c <= wait_cyc; c++) begin
      got_bus = {wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, rsp_valid, req_ready};
      exp_bus = {1'b1, 1'b1, we, adr, dat, sel, 1'b0, 1'b0};
      tests_run++;
      if (got_bus !== exp_bus) begin
        tests_failed++;
        $display("FAIL txn_bus_cycle%0d: got %h expected %h", c, got_bus, exp_bus);
      end
      if (c == wait_cyc) begin
        wb_ack_i = 1'b1;
        sidx = int'(wb_adr_o[5:2]);
        if (wb_we_o) begin
          for (int b = 0; b < 4; b++) if (wb_sel_o[b]) slave_mem[sidx][8*b +: 8] = wb_dat_o[8*b +: 8];
          wb_dat_i = $urandom;
        end else begin
          wb_dat_i = slave_mem[sidx];
        end
      end else begin
        wb_ack_i = 1'b0;
        wb_dat_i = $urandom;
      end
      @(negedge clk);
    end
    wb_ack_i = 1'b0;
    for (int h = 0; h <= hold; h++) begin
      got_rsp = {wb_cyc_o, wb_stb_o, rsp_valid, rsp_err, rsp_dat, req_ready};
      exp_rsp = {1'b0, 1'b0, 1'b1, 1'b0, exp_dat, 1'b0};
      tests_run++;
      if (got_rsp !== exp_rsp) begin
        tests_failed++;
        $display("FAIL txn_resp_hold%0d: got %h expected %h", h, got_rsp, exp_rsp);
      end
      rsp_ready = (h == hold);
      wb_ack_i  = 1'($urandom_range(0, 1));
      wb_dat_i  = $urandom;
      if (keep_req) begin
        req_valid = 1'b1; req_we = nxt_we; req_adr = nxt_adr; req_dat = nxt_dat; req_sel = nxt_sel;
      end
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    wb_ack_i  = 1'b0;
    tests_run++;
    if ({rsp_valid, wb_cyc_o, req_ready} !== 3'b001) begin
      tests_failed++;
      $display("FAIL txn_back_to_idle: got %b expected 001", {rsp_valid, wb_cyc_o, req_ready});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (req_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_req_ready: got %b expected 0", req_ready);
    end
    tests_run++;
    if ({rsp_valid, rsp_dat, rsp_err, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o} !== 106'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h expected 0",
               {rsp_valid, rsp_dat, rsp_err, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o});
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release_ready: got %b expected 1", req_ready);
    end
  endtask

  task automatic test_write();
    run_txn(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 1, 0, 1'b0);
    tests_run++;
    if (slave_mem[1] !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("FAIL write_slave_data: got %h expected deadbeef", slave_mem[1]);
    end
  endtask

  task automatic test_read();
    slave_mem[2] = 32'h0000_00A5;
    ref_mem[2]   = 32'h0000_00A5;
    run_txn(1'b0, 32'h3080_0008, 32'h0, 4'hF, 0, 0, 1'b0);
  endtask

  task automatic test_back_pressure();
    nxt_we = 1'b0; nxt_adr = 32'h3000_0004; nxt_dat = 32'h0; nxt_sel = 4'hF;
    run_txn(1'b1, 32'h3080_000C, 32'h1122_3344, 4'b0101, 0, 5, 1'b1);
    run_txn(nxt_we, nxt_adr, nxt_dat, nxt_sel, 2, 0, 1'b0);
  endtask

  task automatic test_stray_ack();
    for (int i = 0; i < 6; i++) begin
      wb_ack_i = 1'($urandom_range(0, 1));
      wb_dat_i = $urandom;
      @(negedge clk);
      tests_run++;
      if ({wb_cyc_o, wb_stb_o, rsp_valid, req_ready} !== 4'b0001) begin
        tests_failed++;
        $display("FAIL stray_ack_idle%0d: got %b expected 0001", i, {wb_cyc_o, wb_stb_o, rsp_valid, req_ready});
      end
    end
    wb_ack_i = 1'b0;
  endtask

  task automatic test_reset_mid_bus();
    req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h3000_0010; req_sel = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    tests_run++;
    if ({wb_cyc_o, wb_stb_o} !== 2'b11) begin
      tests_failed++;
      $display("FAIL rst_mid_bus_active: got %b expected 11", {wb_cyc_o, wb_stb_o});
    end
    rst = 1'b1;
    wb_ack_i = 1'b1;
    wb_dat_i = 32'hCAFE_F00D;
    @(negedge clk);
    wb_ack_i = 1'b0;
    tests_run++;
    if ({wb_cyc_o, wb_stb_o, rsp_valid, req_ready} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL rst_mid_bus_abort: got %b expected 0000", {wb_cyc_o, wb_stb_o, rsp_valid, req_ready});
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_mid_bus_ready: got %b expected 1", req_ready);
    end
    for (int i = 0; i < 4; i++) begin
      wb_ack_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      tests_run++;
      if ({rsp_valid, wb_cyc_o} !== 2'b00) begin
        tests_failed++;
        $display("FAIL rst_mid_bus_no_rsp%0d: got %b expected 00", i, {rsp_valid, wb_cyc_o});
      end
    end
    wb_ack_i = 1'b0;
  endtask

`ifdef WB_HOST_MASTER_TIMEOUT_EN
  // Read to an unmapped address; ack_at < 0 means the slave never answers.
  task automatic test_timeout_case(input int ack_at, input logic [31:0] rdata);
    logic [34:0] got, exp;
    req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h4000_0000; req_sel = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tests_run++;
      if ({wb_cyc_o, wb_stb_o, rsp_valid} !== 3'b110) begin
        tests_failed++;
        $display("FAIL timeout_bus_cycle%0d: got %b expected 110", c, {wb_cyc_o, wb_stb_o, rsp_valid});
      end
      wb_ack_i = (c == ack_at);
      wb_dat_i = (c == ack_at) ? rdata : $urandom;
      @(negedge clk);
    end
    wb_ack_i = 1'b0;
    got = {wb_cyc_o, rsp_valid, rsp_err, rsp_dat};
    exp = (ack_at < 0) ? {1'b0, 1'b1, 1'b1, 32'h0} : {1'b0, 1'b1, 1'b0, rdata};
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL timeout_result_ack%0d: got %h expected %h", ack_at, got, exp);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_timeout();
    test_timeout_case(-1, 32'h0);
    test_timeout_case(3, 32'h1234_5678);
  endtask
`endif

  task automatic test_random();
    logic [31:0] base, adr, dat;
    logic [3:0]  sel;
    for (int n = 0; n < 40; n++) begin
      base = $urandom_range(0, 1) ? 32'h3000_0000 : 32'h3080_0000;
      adr  = base | {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      dat  = $urandom;
      sel  = 4'($urandom_range(1, 15));
      run_txn(1'($urandom), adr, dat, sel, $urandom_range(0, 3), $urandom_range(0, 2), 1'b0);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      ref_mem[i]   = 32'h0;
      slave_mem[i] = 32'h0;
    end
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_dat = '0; req_sel = '0;
    rsp_ready = 1'b0; wb_ack_i = 1'b0; wb_dat_i = '0;
    test_reset();
    test_write();
    test_read();
    test_back_pressure();
    test_stray_ack();
    test_reset_mid_bus();
`ifdef WB_HOST_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/wb_host_master.md
# wb_host_master

Single-outstanding Wishbone classic initiator: turns a valid/ready request handshake into one Wishbone read or write cycle and returns the result on a valid/ready response handshake. It drives the accelerator's Wishbone slave side (sudoku window 0x3000_0000, UART window 0x3080_0000) from on-chip logic or a test sequencer, acting as the initiator end of the bus that the accelerator top responds on. An optional watchdog aborts cycles whose slave never acknowledges.

## Interface
- TIMEOUT_CYCLES, 255, cycles in BUS without ack before abort (only with timeout compiled in); 1..65535
- wb_clk_i  in  1  clock, all logic on rising edge
- wb_rst_i  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = write, 0 = read
- req_adr  in  32  byte address
- req_dat  in  32  write data
- req_sel  in  4  byte lanes
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_dat  out  32  read data (0 for writes and errors)
- rsp_err  out  1  1 = cycle aborted by timeout
- wb_adr_o  out  32  Wishbone address
- wb_dat_o  out  32  Wishbone write data
- wb_sel_o  out  4  Wishbone byte select
- wb_we_o  out  1  Wishbone write enable
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_ack_i  in  1  Wishbone acknowledge
- wb_dat_i  in  32  Wishbone read data

## Operation
- States: IDLE, BUS, RESP. Reset -> IDLE.
- IDLE: req_ready=1. On req_valid&req_ready: latch we/adr/dat/sel into wb_*_o registers, go BUS.
- BUS: wb_cyc_o=wb_stb_o=1, wb_adr/dat/sel/we stable. On wb_ack_i sampled high: capture wb_dat_i into rsp_dat if read (else 0), rsp_err=0, drop cyc/stb, go RESP.
- RESP: rsp_valid=1, rsp_dat/rsp_err stable. On rsp_valid&rsp_ready: go IDLE. req_ready stays 0 in BUS and RESP (no request accepted in the RESP->IDLE cycle).
- wb_ack_i outside BUS is ignored.
- Reset values: req_ready=0 during reset cycle then 1 in IDLE; rsp_valid=0, rsp_dat=0, rsp_err=0, wb_cyc_o=0, wb_stb_o=0, wb_we_o=0, wb_adr_o=0, wb_dat_o=0, wb_sel_o=0.
- Reset mid-cycle: at the reset edge cyc/stb drop, any pending response is discarded, no response is produced for the aborted request.

## Timing
- Request handshake at edge N -> cyc/stb high from cycle N+1.
- Ack sampled high at edge M -> cyc/stb low and rsp_valid high from cycle M+1; zero-wait slave (ack in first BUS cycle) gives 2-cycle request-to-response latency.
- rsp_ready high in the first RESP cycle -> req_ready high one cycle later; minimum 3 cycles per transaction.
- Watchdog: counter cleared on BUS entry, increments each BUS cycle without ack; when it equals TIMEOUT_CYCLES, abort at that edge: cyc/stb low, rsp_err=1, rsp_dat=0, go RESP. Ack and timeout on the same edge: ack wins, rsp_err=0.
- Counter width: $clog2(TIMEOUT_CYCLES+1); never wraps.

## Configuration
- WB_HOST_MASTER_TIMEOUT_EN defined: watchdog counter and rsp_err as above.
- Undefined: no counter, BUS waits indefinitely for ack, rsp_err tied 0; TIMEOUT_CYCLES unused.

## Structure
- Package wb_host_pkg: state enum (IDLE, BUS, RESP), WB_ADR_W=32, WB_DAT_W=32, WB_SEL_W=4, address window constants SUDOKU_BASE=0x3000_0000, UART_BASE=0x3080_0000, WINDOW_MASK=0xFFF0_0000.
- One sub-module: wb_host_timeout (counter, clear/enable in, expired out), instantiated only under the macro.

## Test plan
- Write 0xDEADBEEF, sel 0xF to 0x3000_0004, slave acks on 2nd BUS cycle -> cyc/stb high exactly 2 cycles, wb_we_o=1, rsp_valid next cycle with rsp_err=0, rsp_dat=0.
- Read 0x3080_0008, zero-wait slave returns 0x0000_00A5 -> rsp_dat=0x0000_00A5, rsp_valid 2 cycles after request handshake.
- Back-pressure: rsp_ready low 5 cycles -> rsp_valid/rsp_dat held, req_ready 0 throughout, new request accepted only after response taken.
- Timeout (macro on, TIMEOUT_CYCLES=4): read 0x4000_0000, no ack -> cyc/stb drop after 4 BUS cycles, rsp_err=1, rsp_dat=0; variant with ack on the 4th cycle -> rsp_err=0.
- Reset asserted during BUS -> cyc/stb 0 next cycle, rsp_valid never asserts, req_ready 1 the cycle after reset deasserts.
- Stray wb_ack_i pulses in IDLE/RESP -> no state change, no extra response.
